vga_timing_irq: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/wrap_counter_split.sv | 49 ++++
 rtl/vga_timing_irq.sv | 122 ++++++++++++
 tb/tb_vga_timing_irq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// XGA raster constants, coordinate field widths and a split-coordinate compare helper.
// Latency: none (constants and a pure function); backpressure: not applicable.
package vga_timing_pkg;

    localparam int XGA_H_ACTIVE = 1024;
    localparam int XGA_H_FP     = 24;
    localparam int XGA_H_SYNC   = 136;
    localparam int XGA_H_BP     = 160;
    localparam int XGA_V_ACTIVE = 768;
    localparam int XGA_V_FP     = 3;
    localparam int XGA_V_SYNC   = 6;
    localparam int XGA_V_BP     = 29;
    localparam logic XGA_SYNC_ACTIVE_LOW = 1'b1;

    localparam int H_SYNC_START  = XGA_H_ACTIVE + XGA_H_FP;
    localparam int H_SYNC_END    = H_SYNC_START + XGA_H_SYNC;
    localparam int H_TOTAL       = H_SYNC_END + XGA_H_BP;
    localparam int V_BLANK_START = XGA_V_ACTIVE;
    localparam int V_SYNC_START  = XGA_V_ACTIVE + XGA_V_FP;
    localparam int V_SYNC_END    = V_SYNC_START + XGA_V_SYNC;
    localparam int V_TOTAL       = V_SYNC_END + XGA_V_BP;

    localparam int X_LO_W = 5;
    localparam int X_HI_W = 6;
    localparam int Y_LO_W = 6;
    localparam int Y_HI_W = 5;
    localparam int X_W    = X_HI_W + X_LO_W;
    localparam int X_DIV  = 32;
    localparam int Y_DIV  = 48;

    // Line index y = hi*48 + lo compared against a constant without forming y.
    function automatic logic y_split_ge(input logic [Y_HI_W-1:0] hi,
                                        input logic [Y_LO_W-1:0] lo,
                                        input int bound);
        logic [Y_HI_W-1:0] b_hi;
        logic [Y_LO_W-1:0] b_lo;
        b_hi = Y_HI_W'(bound / Y_DIV);
        b_lo = Y_LO_W'(bound % Y_DIV);
        return (hi > b_hi) || ((hi == b_hi) && (lo >= b_lo));
    endfunction

endpackage

// File: rtl/wrap_counter_split.sv
// Two-field counter (hi*(LO_MAX+1) + lo) that wraps to zero at a terminal value.
// Latency: next value exposed combinationally, registered value one clock later; backpressure: en only.
module wrap_counter_split #(
    parameter int LO_W   = 5,
    parameter int HI_W   = 6,
    parameter int LO_MAX = 31,
    parameter int LO_END = 31,
    parameter int HI_END = 41
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    output logic [LO_W-1:0] lo_d,
    output logic [HI_W-1:0] hi_d,
    output logic [LO_W-1:0] lo_q,
    output logic [HI_W-1:0] hi_q
);

    localparam logic [LO_W-1:0] LO_MAX_V = LO_W'(LO_MAX);
    localparam logic [LO_W-1:0] LO_END_V = LO_W'(LO_END);
    localparam logic [HI_W-1:0] HI_END_V = HI_W'(HI_END);

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (en) begin
            if ((lo_q == LO_END_V) && (hi_q == HI_END_V)) begin
                lo_d = '0;
                hi_d = '0;
            end else if (lo_q == LO_MAX_V) begin
                lo_d = '0;
                hi_d = hi_q + HI_W'(1);
            end else begin
                lo_d = lo_q + LO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/vga_timing_irq.sv
// Raster timing generator: split x/y coordinates, hsync/vsync/blank and a latched frame interrupt.
// Latency: syncs and blank are registered alongside the coordinates they describe; backpressure: none, free-running.
module vga_timing_irq
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE        = XGA_H_ACTIVE,
    parameter int   H_FP            = XGA_H_FP,
    parameter int   H_SYNC          = XGA_H_SYNC,
    parameter int   H_BP            = XGA_H_BP,
    parameter int   V_ACTIVE        = XGA_V_ACTIVE,
    parameter int   V_FP            = XGA_V_FP,
    parameter int   V_SYNC          = XGA_V_SYNC,
    parameter int   V_BP            = XGA_V_BP,
    parameter logic SYNC_ACTIVE_LOW = XGA_SYNC_ACTIVE_LOW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cli,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              interrupt,
    output logic [X_LO_W-1:0] x_lo,
    output logic [X_HI_W-1:0] x_hi,
    output logic [Y_LO_W-1:0] y_lo,
    output logic [Y_HI_W-1:0] y_hi
);

    localparam int HS_BEGIN    = H_ACTIVE + H_FP;
    localparam int HS_STOP     = HS_BEGIN + H_SYNC;
    localparam int LINE_TOTAL  = HS_STOP + H_BP;
    localparam int VS_BEGIN    = V_ACTIVE + V_FP;
    localparam int VS_STOP     = VS_BEGIN + V_SYNC;
    localparam int FRAME_TOTAL = VS_STOP + V_BP;

    localparam logic [X_LO_W-1:0] X_END_LO = X_LO_W'((LINE_TOTAL - 1) % X_DIV);
    localparam logic [X_HI_W-1:0] X_END_HI = X_HI_W'((LINE_TOTAL - 1) / X_DIV);

    logic [X_LO_W-1:0] x_lo_d, x_lo_q;
    logic [X_HI_W-1:0] x_hi_d, x_hi_q;
    logic [Y_LO_W-1:0] y_lo_d, y_lo_q;
    logic [Y_HI_W-1:0] y_hi_d, y_hi_q;
    logic              x_wrap;
    logic [X_W-1:0]    x_d;

    logic hsync_d, hsync_q;
    logic vsync_d, vsync_q;
    logic blank_d, blank_q;
    logic irq_d, irq_q;
    logic h_act, v_act, frame_start;

    assign x_wrap = (x_hi_q == X_END_HI) && (x_lo_q == X_END_LO);
    assign x_d    = {x_hi_d, x_lo_d};

    wrap_counter_split #(
        .LO_W  (X_LO_W),
        .HI_W  (X_HI_W),
        .LO_MAX(X_DIV - 1),
        .LO_END((LINE_TOTAL - 1) % X_DIV),
        .HI_END((LINE_TOTAL - 1) / X_DIV)
    ) u_x_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .lo_d (x_lo_d),
        .hi_d (x_hi_d),
        .lo_q (x_lo_q),
        .hi_q (x_hi_q)
    );

    wrap_counter_split #(
        .LO_W  (Y_LO_W),
        .HI_W  (Y_HI_W),
        .LO_MAX(Y_DIV - 1),
        .LO_END((FRAME_TOTAL - 1) % Y_DIV),
        .HI_END((FRAME_TOTAL - 1) / Y_DIV)
    ) u_y_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (x_wrap),
        .lo_d (y_lo_d),
        .hi_d (y_hi_d),
        .lo_q (y_lo_q),
        .hi_q (y_hi_q)
    );

    // Decode from the next coordinates so the registered flags line up with them.
    always_comb begin
        h_act       = (x_d >= X_W'(HS_BEGIN)) && (x_d < X_W'(HS_STOP));
        v_act       = y_split_ge(y_hi_d, y_lo_d, VS_BEGIN) && !y_split_ge(y_hi_d, y_lo_d, VS_STOP);
        blank_d     = (x_d >= X_W'(H_ACTIVE)) || y_split_ge(y_hi_d, y_lo_d, V_ACTIVE);
        frame_start = (x_d == '0) && y_split_ge(y_hi_d, y_lo_d, V_ACTIVE)
                      && !y_split_ge(y_hi_d, y_lo_d, V_ACTIVE + 1);
        hsync_d     = h_act ^ SYNC_ACTIVE_LOW;
        vsync_d     = v_act ^ SYNC_ACTIVE_LOW;
        irq_d       = frame_start | (irq_q & ~cli);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= SYNC_ACTIVE_LOW;
            vsync_q <= SYNC_ACTIVE_LOW;
            blank_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            blank_q <= blank_d;
            irq_q   <= irq_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank     = blank_q;
    assign interrupt = irq_q;
    assign x_lo      = x_lo_q;
    assign x_hi      = x_hi_q;
    assign y_lo      = y_lo_q;
    assign y_hi      = y_hi_q;

endmodule

// File: tb/tb_vga_timing_irq.sv
// Bench for vga_timing_irq: an XGA instance plus a shrunken-raster instance checked every clock
// against a plain-arithmetic raster model.
module tb_vga_timing_irq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cli = 1'b0;

    logic       d_hs, d_vs, d_bl, d_irq;
    logic [4:0] d_xlo;
    logic [5:0] d_xhi;
    logic [5:0] d_ylo;
    logic [4:0] d_yhi;
    logic       s_hs, s_vs, s_bl, s_irq;
    logic [4:0] s_xlo;
    logic [5:0] s_xhi;
    logic [5:0] s_ylo;
    logic [4:0] s_yhi;

    vga_timing_irq u_xga (
        .clk(clk), .rst_n(rst_n), .cli(cli),
        .hsync(d_hs), .vsync(d_vs), .blank(d_bl), .interrupt(d_irq),
        .x_lo(d_xlo), .x_hi(d_xhi), .y_lo(d_ylo), .y_hi(d_yhi)
    );

    vga_timing_irq #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(12),
        .V_ACTIVE(60), .V_FP(3), .V_SYNC(6), .V_BP(5),
        .SYNC_ACTIVE_LOW(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .cli(cli),
        .hsync(s_hs), .vsync(s_vs), .blank(s_bl), .interrupt(s_irq),
        .x_lo(s_xlo), .x_hi(s_xhi), .y_lo(s_ylo), .y_hi(s_yhi)
    );

    always #5 clk = ~clk;

    // Raster geometry per instance: [0] = XGA, [1] = small.
    int h_act[2], hs_b[2], hs_e[2], h_tot[2];
    int v_act[2], vs_b[2], vs_e[2], v_tot[2];
    bit act_low[2];

    int m_x[2], m_y[2];
    bit m_irq[2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        logic hs, vs, bl;
        hs = (m_x[i] >= hs_b[i]) && (m_x[i] < hs_e[i]);
        vs = (m_y[i] >= vs_b[i]) && (m_y[i] < vs_e[i]);
        bl = (m_x[i] >= h_act[i]) || (m_y[i] >= v_act[i]);
        if (act_low[i]) begin
            hs = !hs;
            vs = !vs;
        end
        return {6'd0, hs, vs, bl, m_irq[i], 6'(m_x[i] / 32), 5'(m_x[i] % 32),
                5'(m_y[i] / 48), 6'(m_y[i] % 48)};
    endfunction

    function automatic logic [31:0] obs_word(input int i);
        if (i == 0) return {6'd0, d_hs, d_vs, d_bl, d_irq, d_xhi, d_xlo, d_yhi, d_ylo};
        return {6'd0, s_hs, s_vs, s_bl, s_irq, s_xhi, s_xlo, s_yhi, s_ylo};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 0;
            m_y[i] = 0;
            m_irq[i] = 1'b0;
        end
    endtask

    task automatic model_adv(input logic c);
        for (int i = 0; i < 2; i++) begin
            m_x[i]++;
            if (m_x[i] == h_tot[i]) begin
                m_x[i] = 0;
                m_y[i]++;
                if (m_y[i] == v_tot[i]) m_y[i] = 0;
            end
            if (m_x[i] == 0 && m_y[i] == v_act[i]) m_irq[i] = 1'b1;
            else if (c) m_irq[i] = 1'b0;
        end
    endtask

    // One clock: the model sees the cli value the DUT sampled, then both instances are compared.
    task automatic step();
        logic c;
        c = cli;
        @(posedge clk);
        #1;
        model_adv(c);
        chk("word_xga", obs_word(0), exp_word(0));
        chk("word_small", obs_word(1), exp_word(1));
    endtask

    initial begin
        int n, tx, ty;
        h_act = '{1024, 40};  hs_b = '{1048, 44};  hs_e = '{1184, 52};  h_tot = '{1344, 64};
        v_act = '{768, 60};   vs_b = '{771, 63};   vs_e = '{777, 69};   v_tot = '{806, 74};
        act_low = '{1'b1, 1'b0};

        model_reset();
        #12;
        chk("reset_xga", obs_word(0), exp_word(0));
        chk("reset_small", obs_word(1), exp_word(1));
        @(negedge clk);
        rst_n = 1'b1;

        // First frame interrupt of the small raster: 60 lines of 64 clocks.
        n = 0;
        while (!s_irq && n < 10000) begin
            step();
            n++;
        end
        chk("irq_first_latency", 32'(n), 32'd3840);

        repeat (5000) step();
        chk("irq_hold", {31'd0, s_irq}, 32'd1);
        cli = 1'b1;
        step();
        cli = 1'b0;
        chk("irq_clear", {31'd0, s_irq}, 32'd0);
        chk("cli_noop_xga", {31'd0, d_irq}, 32'd0);

        // cli on the very clock that sets the interrupt.
        n = 0;
        while (!(m_x[1] == 63 && m_y[1] == 59) && n < 10000) begin
            step();
            n++;
        end
        chk("set_cycle_reached", 32'(m_x[1] * 100 + m_y[1]), 32'd6359);
        cli = 1'b1;
        step();
        cli = 1'b0;
        chk("irq_set_wins", {31'd0, s_irq}, 32'd1);

        // Random cli traffic while the XGA raster walks past line 48.
        n = 0;
        while (m_y[0] < 49 && n < 70000) begin
            cli = ($urandom_range(0, 399) == 0);
            step();
            n++;
            if (m_x[0] == 0 && m_y[0] == 48)
                chk("y_split_47_48", {21'd0, d_yhi, d_ylo}, {21'd0, 5'd1, 6'd0});
        end
        cli = 1'b0;
        chk("xga_reached_line_49", 32'(m_y[0]), 32'd49);

        // Asynchronous reset at a random point of the small frame.
        tx = $urandom_range(0, 63);
        ty = $urandom_range(1, 73);
        n = 0;
        while (!(m_x[1] == tx && m_y[1] == ty) && n < 6000) begin
            step();
            n++;
        end
        chk("reset_point_reached", 32'(m_x[1] * 100 + m_y[1]), 32'(tx * 100 + ty));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_xga", obs_word(0), exp_word(0));
        chk("async_reset_small", obs_word(1), exp_word(1));
        @(posedge clk);
        #1;
        chk("reset_hold_xga", obs_word(0), exp_word(0));
        chk("reset_hold_small", obs_word(1), exp_word(1));
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!s_irq && n < 10000) begin
            step();
            n++;
        end
        chk("irq_after_reset", 32'(n), 32'd3840);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
